// File: rtl/flash_stream_deserializer.sv
// flash_stream_deserializer: oversamples the flash sequencer's serial link,
// strips the instruction/filler/dummy bits, packs data MSB-first into bytes
// and buffers them in a first-word-fall-through FIFO with per-frame status.
module flash_stream_deserializer #(
    parameter int SKIP_BITS  = 24,
    parameter int FIFO_DEPTH = 16,
    parameter int COUNT_W    = 16
) (
    input  logic                          CLK_16MHZ,
    input  logic                          RESET_N,
    input  logic                          ser_clk,
    input  logic                          ser_cs_n,
    input  logic                          ser_data,
    input  logic                          enable,
    input  logic                          clear_flags,
    output logic [7:0]                    byte_data,
    output logic                          byte_valid,
    input  logic                          byte_ready,
    output logic                          frame_active,
    output logic                          frame_done,
    output logic [COUNT_W-1:0]            frame_bytes,
    output logic                          partial_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int LW     = AW + 1;
    localparam int SKIP_W = (SKIP_BITS > 0) ? $clog2(SKIP_BITS + 1) : 1;
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP_BITS - 1);

    localparam logic [1:0] S_WAIT_IDLE = 2'd0;
    localparam logic [1:0] S_IDLE      = 2'd1;
    localparam logic [1:0] S_SKIP      = 2'd2;
    localparam logic [1:0] S_DATA      = 2'd3;

    // ---------------- input synchronizers ----------------
    logic clk_s1_q, clk_s2_q, clk_s3_q;
    logic cs_s1_q, cs_s2_q, cs_s3_q;
    logic dat_s1_q, dat_s2_q;

    // 2-FF synchronizers plus a third stage on clock and select for edge detect
    always_ff @(posedge CLK_16MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            clk_s1_q <= 1'b0; clk_s2_q <= 1'b0; clk_s3_q <= 1'b0;
            cs_s1_q  <= 1'b0; cs_s2_q  <= 1'b0; cs_s3_q  <= 1'b0;
            dat_s1_q <= 1'b0; dat_s2_q <= 1'b0;
        end else begin
            clk_s1_q <= ser_clk;  clk_s2_q <= clk_s1_q; clk_s3_q <= clk_s2_q;
            cs_s1_q  <= ser_cs_n; cs_s2_q  <= cs_s1_q;  cs_s3_q  <= cs_s2_q;
            dat_s1_q <= ser_data; dat_s2_q <= dat_s1_q;
        end
    end

    logic ser_rise, cs_fall, sample;
    assign ser_rise = clk_s2_q & ~clk_s3_q;
    assign cs_fall  = cs_s3_q & ~cs_s2_q;
    assign sample   = dat_s2_q;

    // ---------------- frame FSM ----------------
    logic [1:0]         state_q, state_d;
    logic [SKIP_W-1:0]  skip_q, skip_d;
    logic [2:0]         bit_q, bit_d;
    logic [6:0]         shift_q, shift_d;
    logic [COUNT_W-1:0] bytes_q, bytes_d;
    logic               push_q, push_d;
    logic [7:0]         pbyte_q, pbyte_d;
    logic               done_q, done_d;
    logic               perr_set;

    // Next-state logic: frame end (cs high) takes priority over a clock edge
    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        bytes_d  = bytes_q;
        push_d   = 1'b0;
        pbyte_d  = pbyte_q;
        done_d   = 1'b0;
        perr_set = 1'b0;
        case (state_q)
            S_WAIT_IDLE: begin
                // never arm in the middle of a frame that was running at reset
                if (cs_s2_q) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (cs_fall && enable) begin
                    skip_d  = '0;
                    bit_d   = '0;
                    bytes_d = '0;
                    state_d = (SKIP_BITS == 0) ? S_DATA : S_SKIP;
                end
            end
            S_SKIP: begin
                if (cs_s2_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (ser_rise) begin
                    if (skip_q == SKIP_LAST) state_d = S_DATA;
                    else                     skip_d  = skip_q + 1'b1;
                end
            end
            default: begin // S_DATA
                if (cs_s2_q) begin
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                    perr_set = (bit_q != 3'd0);
                end else if (ser_rise) begin
                    shift_d = {shift_q[5:0], sample};
                    if (bit_q == 3'd7) begin
                        push_d  = 1'b1;
                        pbyte_d = {shift_q, sample};
                        bit_d   = 3'd0;
                        // dropped bytes still count; saturate rather than wrap
                        if (bytes_q != {COUNT_W{1'b1}}) bytes_d = bytes_q + 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // FSM and datapath registers; the byte push is staged one cycle
    always_ff @(posedge CLK_16MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_WAIT_IDLE;
            skip_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            bytes_q <= '0;
            push_q  <= 1'b0;
            pbyte_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            bytes_q <= bytes_d;
            push_q  <= push_d;
            pbyte_q <= pbyte_d;
            done_q  <= done_d;
        end
    end

    // ---------------- byte FIFO ----------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] count_q;
    logic          fifo_full, pop, wr_en, ovf_set;

    assign fifo_full = (count_q == LW'(FIFO_DEPTH));
    assign pop       = (count_q != '0) & byte_ready;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign wr_en     = push_q & (~fifo_full | pop);
    assign ovf_set   = push_q & fifo_full & ~pop;

    // Storage array, written only on an accepted push
    always_ff @(posedge CLK_16MHZ) begin
        if (wr_en) mem_q[wr_ptr_q] <= pbyte_q;
    end

    // Pointers wrap naturally since the depth is a power of two
    always_ff @(posedge CLK_16MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky status flags; a set event beats a simultaneous clear
    logic perr_q, ovf_q;
    always_ff @(posedge CLK_16MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            perr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (perr_set)         perr_q <= 1'b1;
            else if (clear_flags) perr_q <= 1'b0;
            if (ovf_set)          ovf_q  <= 1'b1;
            else if (clear_flags) ovf_q  <= 1'b0;
        end
    end

    assign byte_valid   = (count_q != '0);
    assign byte_data    = byte_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_level   = count_q;
    assign frame_active = (state_q == S_SKIP) || (state_q == S_DATA);
    assign frame_done   = done_q;
    assign frame_bytes  = bytes_q;
    assign partial_err  = perr_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_flash_stream_deserializer.sv
// Bench for flash_stream_deserializer: directed frames on the serial link,
// expected bytes kept in a scoreboard queue and checked as they are popped.
`timescale 1ns/1ps
module tb_flash_stream_deserializer;

    logic clk = 1'b0, rst_n = 1'b0;
    logic ser_clk = 1'b0, ser_cs_n = 1'b1, ser_data = 1'b0;
    logic enable = 1'b0, clear_flags = 1'b0, byte_ready = 1'b0;
    logic [7:0]  byte_data;
    logic        byte_valid, frame_active, frame_done, partial_err, overflow;
    logic [15:0] frame_bytes;
    logic [4:0]  fifo_level;

    int checks = 0, errors = 0, done_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    flash_stream_deserializer #(.SKIP_BITS(24), .FIFO_DEPTH(16), .COUNT_W(16)) dut (
        .CLK_16MHZ(clk), .RESET_N(rst_n), .ser_clk(ser_clk), .ser_cs_n(ser_cs_n),
        .ser_data(ser_data), .enable(enable), .clear_flags(clear_flags),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .frame_active(frame_active), .frame_done(frame_done), .frame_bytes(frame_bytes),
        .partial_err(partial_err), .overflow(overflow), .fifo_level(fifo_level)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: compare every accepted byte against the oldest expected one
    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (rst_n && byte_valid && byte_ready) begin
            if (exp_q.size() == 0) chk("sb_unexpected", 32'(byte_valid), 32'd0);
            else                   chk("sb_byte", 32'(byte_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic send_bit(input logic b);
        ser_clk = 1'b0; ser_data = b; step(8);
        ser_clk = 1'b1; step(8);
    endtask

    task automatic start_frame();
        ser_clk = 1'b0; ser_cs_n = 1'b0; step(8);
        repeat (24) send_bit(1'($urandom_range(0, 1)));
    endtask

    task automatic end_frame();
        ser_clk = 1'b0; step(4);
        ser_cs_n = 1'b1; step(10);
    endtask

    // mode 0: plain; 1: latency check on last bit; 2: pop exactly at the push cycle
    task automatic send_byte(input logic [7:0] b, input bit expect_out, input int mode);
        for (int i = 7; i >= 1; i--) send_bit(b[i]);
        ser_clk = 1'b0; ser_data = b[0]; step(8);
        ser_clk = 1'b1;
        if (expect_out) exp_q.push_back(b);
        if (mode == 1) begin
            step(3);
            chk("lat_before", 32'(byte_valid), 32'd0);
            step(1);
            chk("lat_valid", 32'(byte_valid), 32'd1);
            chk("lat_data", 32'(byte_data), 32'(b));
            step(4);
        end else if (mode == 2) begin
            step(3);
            byte_ready = 1'b1;
            step(1);
            byte_ready = 1'b0;
            chk("full_pp_level", 32'(fifo_level), 32'd16);
            chk("full_pp_ovf", 32'(overflow), 32'd0);
            step(4);
        end else begin
            step(8);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        byte_ready = 1'b1;
        while ((exp_q.size() != 0 || byte_valid) && n < 200) begin
            step(1);
            n++;
        end
        byte_ready = 1'b0;
        chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_valid"}, 32'(byte_valid), 32'd0);
    endtask

    initial begin
        int d0;
        // reset state
        step(3);
        chk("rst_valid", 32'(byte_valid), 32'd0);
        chk("rst_data", 32'(byte_data), 32'd0);
        chk("rst_active", 32'(frame_active), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_bytes", 32'(frame_bytes), 32'd0);
        chk("rst_perr", 32'(partial_err), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        rst_n = 1'b1; enable = 1'b1; step(6);

        // single frame A5 3C
        byte_ready = 1'b1;
        d0 = done_cnt;
        start_frame();
        chk("t1_active", 32'(frame_active), 32'd1);
        send_byte(8'hA5, 1'b1, 0);
        send_byte(8'h3C, 1'b1, 0);
        end_frame();
        chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("t1_bytes", 32'(frame_bytes), 32'd2);
        chk("t1_perr", 32'(partial_err), 32'd0);
        chk("t1_ovf", 32'(overflow), 32'd0);
        chk("t1_inactive", 32'(frame_active), 32'd0);
        drain("t1");

        // latency from raw edge of the last bit
        byte_ready = 1'b0;
        start_frame();
        send_byte(8'h81, 1'b1, 1);
        end_frame();
        drain("t2");

        // partial byte
        byte_ready = 1'b1;
        start_frame();
        send_byte(8'hFF, 1'b1, 0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        end_frame();
        chk("t3_bytes", 32'(frame_bytes), 32'd1);
        chk("t3_perr", 32'(partial_err), 32'd1);
        chk("t3_ovf", 32'(overflow), 32'd0);
        clear_flags = 1'b1; step(1); clear_flags = 1'b0;
        chk("t3_perr_clr", 32'(partial_err), 32'd0);
        drain("t3");

        // overflow: 17 bytes into a 16-deep FIFO, last one dropped
        byte_ready = 1'b0;
        start_frame();
        for (int i = 0; i < 17; i++) send_byte(8'(i), (i < 16), 0);
        end_frame();
        chk("t4_level", 32'(fifo_level), 32'd16);
        chk("t4_ovf", 32'(overflow), 32'd1);
        chk("t4_bytes", 32'(frame_bytes), 32'd17);
        drain("t4");
        clear_flags = 1'b1; step(1); clear_flags = 1'b0;
        chk("t4_ovf_clr", 32'(overflow), 32'd0);

        // full FIFO with simultaneous push and pop
        start_frame();
        for (int i = 0; i < 16; i++) send_byte(8'h40 + 8'(i), 1'b1, 0);
        send_byte(8'h50, 1'b1, 2);
        end_frame();
        chk("t5_ovf", 32'(overflow), 32'd0);
        chk("t5_level", 32'(fifo_level), 32'd16);
        chk("t5_bytes", 32'(frame_bytes), 32'd17);
        drain("t5");

        // disabled: frame ignored
        enable = 1'b0;
        start_frame();
        send_byte(8'h11, 1'b0, 0);
        chk("t6_inactive", 32'(frame_active), 32'd0);
        end_frame();
        chk("t6_level", 32'(fifo_level), 32'd0);
        enable = 1'b1;

        // reset mid-frame, release with cs still low
        start_frame();
        repeat (4) send_bit(1'b1);
        rst_n = 1'b0; step(2);
        chk("t7_rst_active", 32'(frame_active), 32'd0);
        rst_n = 1'b1;
        repeat (16) send_bit(1'($urandom_range(0, 1)));
        chk("t7_active", 32'(frame_active), 32'd0);
        chk("t7_level", 32'(fifo_level), 32'd0);
        chk("t7_valid", 32'(byte_valid), 32'd0);
        end_frame();
        byte_ready = 1'b1;
        start_frame();
        send_byte(8'h5A, 1'b1, 0);
        end_frame();
        chk("t7_bytes", 32'(frame_bytes), 32'd1);
        drain("t7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
